rs_block_arbiter: RTL and testbench
===================================

RS_BLOCK_ARBITER -- requirements
Module: rs_block_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, meaning the number of byte-stream requesters (2..8).
REQ-002 SHALL have parameter BLOCK_LEN, default 223, meaning the RS message bytes per block.
REQ-003 SHALL have parameter PAD_BYTE, default 8'h00, meaning the fill byte for short blocks.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port tx_en  in  1  permits new block grants.
REQ-007 SHALL have port s_axis_valid  in  NUM_SRC  per-source valid.
REQ-008 SHALL have port s_axis_ready  out  NUM_SRC  per-source ready.
REQ-009 SHALL have port s_axis_data  in  8*NUM_SRC  per-source byte; source k uses bits [8k+7:8k].
REQ-010 SHALL have port s_axis_last  in  NUM_SRC  per-source end-of-message.
REQ-011 SHALL have ports m_axis_valid/ready/data/last  out/in/out/out  1/1/8/1  block stream to tx_chain.
REQ-012 SHALL have port grant_id  out  max(1,$clog2(NUM_SRC))  index of the source owning the current block.
REQ-013 SHALL have port busy  out  1  high while in PASS or PAD.
REQ-014 SHALL have port len_err  out  1  one-cycle pulse on a block-length violation.
REQ-015 SHALL have port blk_count  out  16  completed output blocks; wraps at 2^16.

Function
REQ-016 SHALL implement the states IDLE, PASS and PAD.
REQ-017 SHALL, in IDLE with tx_en=1 and any s_axis_valid high, grant the first valid source found searching upward from (last_grant+1) mod NUM_SRC, load grant_id, clear byte count and enter PASS on the next edge.
REQ-018 SHALL transfer no byte in IDLE; grant latency SHALL be exactly one cycle.
REQ-019 SHALL, in PASS, drive m_axis_valid = s_axis_valid[grant_id], m_axis_data = the granted byte, and s_axis_ready[grant_id] = m_axis_ready, all combinationally.
REQ-020 SHALL hold s_axis_ready low for every non-granted source, and for all sources outside PASS.
REQ-021 SHALL drive m_axis_last = (count == BLOCK_LEN-1) in PASS and PAD; the source's s_axis_last is never forwarded.
REQ-022 SHALL increment count only on an m_axis handshake (valid & ready).
REQ-023 SHALL, on a PASS handshake with s_axis_last=1 and count < BLOCK_LEN-1, pulse len_err and enter PAD.
REQ-024 SHALL, in PAD, drive m_axis_valid=1 and m_axis_data=PAD_BYTE until the handshake at count==BLOCK_LEN-1.
REQ-025 SHALL, on the handshake at count==BLOCK_LEN-1 (PASS or PAD), return to IDLE, set last_grant=grant_id and increment blk_count.
REQ-026 SHALL pulse len_err on that final PASS handshake if s_axis_last=0; the source's remaining bytes then compete as a new block.
REQ-027 SHALL allow tx_en deassertion mid-block to complete the current block, blocking only new grants.
REQ-028 SHALL, with m_axis_ready=0, hold m_axis_data/last stable while m_axis_valid is high (AXIS stability).
REQ-029 SHALL assert busy = (state != IDLE).

Reset
REQ-030 SHALL, on rst=1 at a clock edge, force state IDLE, count 0, last_grant NUM_SRC-1 (so source 0 has first priority), grant_id 0, blk_count 0, and len_err, busy, m_axis_valid and all s_axis_ready low.
REQ-031 SHALL abandon any partial block when rst is asserted mid-block, with no padding and no blk_count increment.

Verification
REQ-032 SHALL be verified by: src0 sends 223 bytes with last on byte 223, m_ready=1 -> 223 bytes out in order, m_last on byte 223 only, blk_count=1, len_err never high.
REQ-033 SHALL be verified by: src0 and src1 both continuously valid for 4 blocks -> grant_id sequence 0,1,0,1, with exactly 1 idle cycle between blocks.
REQ-034 SHALL be verified by: src1 asserts last on byte 100 -> len_err pulses once, output bytes 101..223 = 8'h00, m_last on byte 223.
REQ-035 SHALL be verified by: src0 sends 300 bytes with no last -> m_last at byte 223, len_err pulses once, bytes 224..300 start a new block.
REQ-036 SHALL be verified by: random m_ready backpressure with tx_en dropped at byte 50 -> block completes intact, no new grant while tx_en=0.
REQ-037 SHALL be verified by: rst pulsed at byte 120 -> next cycle m_valid=0, busy=0, blk_count unchanged from pre-block value; the next grant goes to src0.

Source files
------------

// File: rtl/rs_block_arbiter.sv
// Round-robin arbiter that packs per-source byte streams into fixed-length
// RS message blocks. Short messages are padded with PAD_BYTE and overlong
// messages are cut at BLOCK_LEN, with len_err pulsing on either violation.
module rs_block_arbiter #(
    parameter int         NUM_SRC   = 2,
    parameter int         BLOCK_LEN = 223,
    parameter logic [7:0] PAD_BYTE  = 8'h00
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       tx_en,
    input  logic [NUM_SRC-1:0]                         s_axis_valid,
    output logic [NUM_SRC-1:0]                         s_axis_ready,
    input  logic [8*NUM_SRC-1:0]                       s_axis_data,
    input  logic [NUM_SRC-1:0]                         s_axis_last,
    output logic                                       m_axis_valid,
    input  logic                                       m_axis_ready,
    output logic [7:0]                                 m_axis_data,
    output logic                                       m_axis_last,
    output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] grant_id,
    output logic                                       busy,
    output logic                                       len_err,
    output logic [15:0]                                blk_count
);

    localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

    typedef enum logic [1:0] {IDLE, PASS, PAD} state_t;

    state_t        state, state_n;
    logic [CW-1:0] count, count_n;
    logic [GW-1:0] grant_n;
    logic [GW-1:0] last_grant, last_grant_n;
    logic [15:0]   blk_count_n;
    logic          len_err_n;

    logic [7:0]    src_bytes [NUM_SRC];
    logic          sel_valid, sel_last;
    logic [7:0]    sel_data;
    logic          at_end, hs;
    logic          found;
    logic [GW-1:0] pick, idx;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign src_bytes[g] = s_axis_data[8*g +: 8];
    end

    // Round-robin search starting just above the previous block's owner
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            idx = GW'((32'(last_grant) + i) % NUM_SRC);
            if (!found && s_axis_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Output mux and next-state / datapath update
    always_comb begin
        sel_valid    = s_axis_valid[grant_id];
        sel_last     = s_axis_last[grant_id];
        sel_data     = src_bytes[grant_id];
        at_end       = (count == CW'(BLOCK_LEN - 1));

        s_axis_ready = '0;
        m_axis_valid = 1'b0;
        m_axis_data  = '0;
        m_axis_last  = 1'b0;
        busy         = (state != IDLE);

        case (state)
            PASS: begin
                m_axis_valid           = sel_valid;
                m_axis_data            = sel_data;
                m_axis_last            = at_end;
                s_axis_ready[grant_id] = m_axis_ready;
            end
            PAD: begin
                m_axis_valid = 1'b1;
                m_axis_data  = PAD_BYTE;
                m_axis_last  = at_end;
            end
            default: ;
        endcase

        hs = m_axis_valid & m_axis_ready;

        state_n      = state;
        count_n      = count;
        grant_n      = grant_id;
        last_grant_n = last_grant;
        blk_count_n  = blk_count;
        len_err_n    = 1'b0;

        case (state)
            IDLE: begin
                if (tx_en && found) begin
                    state_n = PASS;
                    grant_n = pick;
                    count_n = '0;
                end
            end
            PASS: begin
                if (hs) begin
                    if (at_end) begin
                        state_n      = IDLE;
                        last_grant_n = grant_id;
                        blk_count_n  = blk_count + 16'd1;
                        len_err_n    = !sel_last;
                    end else begin
                        count_n = count + 1'b1;
                        if (sel_last) begin
                            state_n   = PAD;
                            len_err_n = 1'b1;
                        end
                    end
                end
            end
            PAD: begin
                if (hs) begin
                    if (at_end) begin
                        state_n      = IDLE;
                        last_grant_n = grant_id;
                        blk_count_n  = blk_count + 16'd1;
                    end else begin
                        count_n = count + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any partial block
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            grant_id   <= '0;
            last_grant <= GW'(NUM_SRC - 1);
            blk_count  <= '0;
            len_err    <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            grant_id   <= grant_n;
            last_grant <= last_grant_n;
            blk_count  <= blk_count_n;
            len_err    <= len_err_n;
        end
    end

endmodule

// File: tb/tb_rs_block_arbiter.sv
// Directed bench for rs_block_arbiter with two sources and 223-byte blocks.
module tb_rs_block_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_en;
    logic [1:0]  s_axis_valid;
    logic [1:0]  s_axis_ready;
    logic [15:0] s_axis_data;
    logic [1:0]  s_axis_last;
    logic        m_axis_valid;
    logic        m_axis_ready;
    logic [7:0]  m_axis_data;
    logic        m_axis_last;
    logic [0:0]  grant_id;
    logic        busy;
    logic        len_err;
    logic [15:0] blk_count;

    rs_block_arbiter #(.NUM_SRC(2), .BLOCK_LEN(223), .PAD_BYTE(8'h00)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en),
        .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
        .s_axis_data(s_axis_data), .s_axis_last(s_axis_last),
        .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
        .m_axis_data(m_axis_data), .m_axis_last(m_axis_last),
        .grant_id(grant_id), .busy(busy), .len_err(len_err), .blk_count(blk_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int src_len [2];
    int src_last_at [2];
    int src_ptr [2];

    logic [7:0] out_data [1024];
    logic       out_last [1024];
    int         out_gid  [1024];
    int         out_cyc  [1024];
    int         n_out, cyc, len_err_cnt, stab_err, drop_at;
    bit         mready_rand, prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] src_byte(int k, int i);
        return 8'(i * 3 + k * 101 + 7);
    endfunction

    function automatic logic src_v(int k);
        return src_ptr[k] < src_len[k];
    endfunction

    function automatic logic src_l(int k);
        return src_v(k) && (src_ptr[k] + 1 == src_last_at[k]);
    endfunction

    function automatic logic [7:0] src_d(int k);
        return src_v(k) ? src_byte(k, src_ptr[k]) : 8'h00;
    endfunction

    function automatic int count_lasts();
        int c = 0;
        for (int i = 0; i < n_out && i < 1024; i++) if (out_last[i]) c++;
        return c;
    endfunction

    task automatic clear_run();
        for (int k = 0; k < 2; k++) begin
            src_len[k] = 0; src_last_at[k] = 0; src_ptr[k] = 0;
        end
        n_out = 0; cyc = 0; len_err_cnt = 0; stab_err = 0;
        drop_at = -1; tx_en = 1'b1; mready_rand = 1'b0; prev_stall = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tx_en = 1'b1; m_axis_ready = 1'b1;
        s_axis_valid = '0; s_axis_data = '0; s_axis_last = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One clock: drive at posedge+1, observe at negedge, return at posedge+1
    task automatic cycle();
        if (drop_at >= 0 && n_out >= drop_at) tx_en = 1'b0;
        s_axis_valid = {src_v(1), src_v(0)};
        s_axis_last  = {src_l(1), src_l(0)};
        s_axis_data  = {src_d(1), src_d(0)};
        m_axis_ready = mready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        if (prev_stall && (!m_axis_valid || m_axis_data !== prev_data || m_axis_last !== prev_last))
            stab_err++;
        prev_stall = m_axis_valid && !m_axis_ready;
        prev_data  = m_axis_data;
        prev_last  = m_axis_last;
        if (len_err) len_err_cnt++;
        if (m_axis_valid && m_axis_ready && n_out < 1024) begin
            out_data[n_out] = m_axis_data;
            out_last[n_out] = m_axis_last;
            out_gid[n_out]  = 32'(grant_id);
            out_cyc[n_out]  = cyc;
            n_out++;
        end
        if (s_axis_ready[0] && s_axis_valid[0]) src_ptr[0]++;
        if (s_axis_ready[1] && s_axis_valid[1]) src_ptr[1]++;
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic run_blocks(input string tag, input int target, input int budget);
        int n = 0;
        while (blk_count != 16'(target) && n < budget) begin
            cycle();
            n++;
        end
        check_eq(tag, 32'(blk_count), target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad, busy_cnt, n;

        // Reset state
        clear_run();
        do_reset();
        check_eq("rst_m_valid", 32'(m_axis_valid), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_blk_count", 32'(blk_count), 0);
        check_eq("rst_len_err", 32'(len_err), 0);
        check_eq("rst_s_ready", 32'(s_axis_ready), 0);
        check_eq("rst_grant_id", 32'(grant_id), 0);

        // Exact-length block from src0
        clear_run();
        src_len[0] = 223; src_last_at[0] = 223;
        cycle();
        check_eq("t1_grant_latency", n_out, 0);
        check_eq("t1_busy", 32'(busy), 1);
        run_blocks("t1_blocks", 1, 600);
        repeat (3) cycle();
        check_eq("t1_n_out", n_out, 223);
        bad = 0;
        for (int i = 0; i < 223; i++) if (out_data[i] !== src_byte(0, i)) bad++;
        check_eq("t1_data_mism", bad, 0);
        check_eq("t1_last_cnt", count_lasts(), 1);
        check_eq("t1_last_pos", 32'(out_last[222]), 1);
        check_eq("t1_len_err", len_err_cnt, 0);

        // Two continuous sources alternate with one idle cycle between blocks
        do_reset();
        clear_run();
        src_len[0] = 1000; src_len[1] = 1000;
        run_blocks("t2_blocks", 4, 1200);
        check_eq("t2_n_out", n_out, 892);
        for (int b = 0; b < 4; b++) check_eq("t2_gid", out_gid[223 * b], b % 2);
        for (int b = 1; b < 4; b++) check_eq("t2_gap", out_cyc[223 * b] - out_cyc[223 * b - 1], 2);
        bad = 0;
        for (int b = 0; b < 4; b++)
            for (int j = 0; j < 223; j++)
                if (out_data[223 * b + j] !== src_byte(b % 2, (b / 2) * 223 + j)) bad++;
        check_eq("t2_data_mism", bad, 0);

        // Short message from src1 is padded
        do_reset();
        clear_run();
        src_len[1] = 100; src_last_at[1] = 100;
        run_blocks("t3_blocks", 1, 600);
        repeat (3) cycle();
        check_eq("t3_n_out", n_out, 223);
        check_eq("t3_gid", out_gid[0], 1);
        bad = 0;
        for (int j = 0; j < 223; j++)
            if (out_data[j] !== ((j < 100) ? src_byte(1, j) : 8'h00)) bad++;
        check_eq("t3_data_mism", bad, 0);
        check_eq("t3_last_cnt", count_lasts(), 1);
        check_eq("t3_last_pos", 32'(out_last[222]), 1);
        check_eq("t3_len_err", len_err_cnt, 1);
        check_eq("t3_src_taken", src_ptr[1], 100);

        // Overlong message from src0 is split
        do_reset();
        clear_run();
        src_len[0] = 300;
        n = 0;
        while (n_out < 300 && n < 900) begin cycle(); n++; end
        repeat (3) cycle();
        check_eq("t4_n_out", n_out, 300);
        check_eq("t4_blk_count", 32'(blk_count), 1);
        check_eq("t4_len_err", len_err_cnt, 1);
        bad = 0;
        for (int i = 0; i < 300; i++) if (out_data[i] !== src_byte(0, i)) bad++;
        check_eq("t4_data_mism", bad, 0);
        check_eq("t4_last_cnt", count_lasts(), 1);
        check_eq("t4_last_pos", 32'(out_last[222]), 1);
        check_eq("t4_gid2", out_gid[223], 0);
        check_eq("t4_gap", out_cyc[223] - out_cyc[222], 2);
        check_eq("t4_busy", 32'(busy), 1);

        // Backpressure with tx_en dropped mid-block
        do_reset();
        clear_run();
        src_len[0] = 223; src_last_at[0] = 223;
        src_len[1] = 223; src_last_at[1] = 223;
        mready_rand = 1'b1; drop_at = 50;
        run_blocks("t5_blocks", 1, 2000);
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (busy) busy_cnt++;
        end
        check_eq("t5_n_out", n_out, 223);
        check_eq("t5_gid", out_gid[0], 0);
        bad = 0;
        for (int i = 0; i < 223; i++) if (out_data[i] !== src_byte(0, i)) bad++;
        check_eq("t5_data_mism", bad, 0);
        check_eq("t5_last_cnt", count_lasts(), 1);
        check_eq("t5_last_pos", 32'(out_last[222]), 1);
        check_eq("t5_len_err", len_err_cnt, 0);
        check_eq("t5_stability", stab_err, 0);
        check_eq("t5_no_grant", busy_cnt, 0);
        drop_at = -1; tx_en = 1'b1; mready_rand = 1'b0;
        run_blocks("t5_resume", 2, 600);
        check_eq("t5_gid2", out_gid[223], 1);

        // Reset in the middle of a src1 block
        do_reset();
        clear_run();
        src_len[1] = 223; src_last_at[1] = 223;
        n = 0;
        while (n_out < 120 && n < 600) begin cycle(); n++; end
        check_eq("t6_reached", n_out, 120);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("t6_m_valid", 32'(m_axis_valid), 0);
        check_eq("t6_busy", 32'(busy), 0);
        check_eq("t6_blk_count", 32'(blk_count), 0);
        check_eq("t6_s_ready", 32'(s_axis_ready), 0);
        src_len[0] = 50;
        cycle();
        check_eq("t6_grant", 32'(grant_id), 0);
        check_eq("t6_busy2", 32'(busy), 1);
        cycle();
        check_eq("t6_first_gid", out_gid[n_out - 1], 0);
        check_eq("t6_first_byte", 32'(out_data[n_out - 1]), 32'(src_byte(0, 0)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
